ucq_scheduler: RTL and testbench
================================

Name: ucq_scheduler

Overview:
Unit-clause queue and dispatch controller that sequences the clause-queue lookup datapath.
- Collects implied unit literals from NUM_ENG BCP engines, plus the initial decision literal, into one FIFO (the UCQ).
- Round-robin arbitration admits at most one literal per cycle.
- Broadcasts one literal at a time to all clause queues as ucarb2clq_uc_rqst, then waits until every engine reports done before issuing the next.
- On any engine conflict it flushes the queue and reports the conflict.

Parameters:
NUM_ENG, 4, number of BCP engines / clause-queue slices served
UCQ_DEPTH, 16, FIFO entries; must be a power of 2
LIT_IDX_MAX, `LIT_IDX_MAX, literal magnitude range; lit_t is $clog2(LIT_IDX_MAX)+1 bits, sign bit at MSB, negative literals two's complement

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-high (despite the name)
dec_lit  in  lit_t  decision literal from host/decision unit
dec_valid  in  1  decision literal valid
dec_ready  out  1  decision accepted this cycle when dec_valid&&dec_ready
eng2ucq_lit  in  [NUM_ENG] lit_t  implied literal per engine
eng2ucq_valid  in  NUM_ENG  implied literal valid; held until ready
ucq2eng_ready  out  NUM_ENG  one-hot grant; push happens when valid&&ready
eng2ucq_done  in  NUM_ENG  per-engine single-cycle pulse: finished current literal
eng2ucq_conflict  in  NUM_ENG  per-engine single-cycle pulse: conflict found
ucarb2clq_uc_rqst  out  lit_t  literal broadcast to all clause queues
ucarb2clq_uc_rqst_valid  out  1  single-cycle request strobe
sched_busy  out  1  state!=IDLE or count!=0
sched_conflict  out  1  single-cycle conflict report
ucq_count  out  $clog2(UCQ_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=1): state=IDLE, head=tail=count=0, rr_ptr=0, done_mask=0. All outputs go to 0 immediately, without a clock edge; dec_ready follows the IDLE/empty rule once reset is released.
- FIFO:
  - head/tail wrap mod UCQ_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - Full: all ready=0 and dec_ready=0. Nothing is dropped; engines hold valid.
  - Empty pop cannot occur (FSM gate).
- Arbitration (rr_arbiter):
  - Grant goes to the first eng2ucq_valid at or after rr_ptr, modulo NUM_ENG.
  - Grant is asserted only when !full and state!=CONFLICT.
  - On grant, rr_ptr <= granted+1 mod NUM_ENG. No grant leaves rr_ptr unchanged.
  - ucq2eng_ready is combinational from valid/rr_ptr/full/state.
- Decision literal: dec_ready = (state==IDLE)&&(count==0)&&!(|eng2ucq_valid). It pushes into the same FIFO.
- FSM (Moore outputs):
  - IDLE: count>0 -> ISSUE.
  - ISSUE: drive rqst=FIFO head, rqst_valid=1, pop, clear done_mask -> WAIT.
  - WAIT: done_mask |= eng2ucq_done.
    - Any conflict -> CONFLICT.
    - Else, when (done_mask|eng2ucq_done) is all-ones: count_next>0 -> ISSUE, else -> IDLE.
  - CONFLICT: sched_conflict=1, head=tail=count=0, done_mask=0, no grants -> IDLE. Pushes granted in the detecting cycle are also flushed.
- Conflict is also sampled in ISSUE, which then goes to CONFLICT; the ISSUE request still strobes.
- Conflict takes precedence over simultaneous completion of done_mask.
- Latency: decision accepted at cycle 0 -> count=1 at cycle 1 (IDLE) -> rqst_valid at cycle 2. Back-to-back issue spacing is at least 2 cycles (ISSUE + ≥1 WAIT).
- done or conflict pulses outside WAIT/ISSUE are ignored.

Decomposition:
- Package sat_pkg: lit_t, LIT_IDX_MAX, UCQ_DEPTH, NUM_ENG, sched_state_t enum {IDLE, ISSUE, WAIT, CONFLICT}.
- Sub-module rr_arbiter #(N): inputs req, rr_ptr, enable; output one-hot grant plus grant index.
- FIFO storage stays inline.

Test Plan:
- Reset release, dec_lit=5 with dec_valid at cycle 0 -> dec_ready=1 at cycle 0; rqst=5, rqst_valid=1 at cycle 2 only; sched_busy=1 from cycle 1.
- rr_ptr=0, engines 0 and 2 push 3 and -7 simultaneously -> eng0 granted cycle k, eng2 cycle k+1, rr_ptr=3; broadcast order 3 then -7.
- Sixteen pushes during a long WAIT -> ucq_count=16 and all ready=0. Engine valid held; after completion, pop -> that engine granted the following cycle.
- Staggered done: eng0@3, eng1@4, eng2@8, eng3@6 after ISSUE@2 -> next ISSUE exactly at cycle 9.
- 4 entries queued, eng1 conflict in WAIT -> sched_conflict=1 one cycle; ucq_count=0 next cycle; state IDLE; no further rqst_valid.
- Assert rst_n mid-WAIT between clock edges -> rqst_valid, ready, sched_busy, ucq_count all 0 immediately.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared SAT-accelerator types: literal encoding and the unit-clause scheduler state set.
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 64
`endif

package sat_pkg;

    localparam int LIT_IDX_MAX = `LIT_IDX_MAX;
    localparam int LIT_W       = $clog2(LIT_IDX_MAX) + 1;
    localparam int NUM_ENG     = 4;
    localparam int UCQ_DEPTH   = 16;

    // Sign at MSB; negated literals are stored in two's complement.
    typedef logic signed [LIT_W-1:0] lit_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        CONFLICT
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(rr_ptr) + i) % N);
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/ucq_scheduler.sv
// Unit-clause queue: merges engine implications and the decision literal into one FIFO,
// broadcasts one literal at a time to the clause queues, and flushes on conflict.
module ucq_scheduler
    import sat_pkg::*;
#(
    parameter int NUM_ENG   = sat_pkg::NUM_ENG,
    parameter int UCQ_DEPTH = sat_pkg::UCQ_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  lit_t                         dec_lit,
    input  logic                         dec_valid,
    output logic                         dec_ready,
    input  lit_t                         eng2ucq_lit [NUM_ENG],
    input  logic [NUM_ENG-1:0]           eng2ucq_valid,
    output logic [NUM_ENG-1:0]           ucq2eng_ready,
    input  logic [NUM_ENG-1:0]           eng2ucq_done,
    input  logic [NUM_ENG-1:0]           eng2ucq_conflict,
    output lit_t                         ucarb2clq_uc_rqst,
    output logic                         ucarb2clq_uc_rqst_valid,
    output logic                         sched_busy,
    output logic                         sched_conflict,
    output logic [$clog2(UCQ_DEPTH):0]   ucq_count
);

    localparam int PW = $clog2(UCQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    sched_state_t       state, state_next;
    lit_t               mem [UCQ_DEPTH];
    logic [PW-1:0]      head, tail;
    logic [CW-1:0]      count, count_next;
    logic [EW-1:0]      rr_ptr, grant_idx;
    logic [NUM_ENG-1:0] done_mask, done_mask_next, grant;
    logic               full, arb_en, push_eng, push_dec, push, pop, flush;
    lit_t               push_lit;

    // rst_n is active-high; gating with it keeps the handshakes low while reset is held.
    assign full   = (count == CW'(UCQ_DEPTH));
    assign arb_en = !rst_n && !full && (state != CONFLICT);

    rr_arbiter #(
        .N  (NUM_ENG),
        .IW (EW)
    ) u_rr_arbiter (
        .req       (eng2ucq_valid),
        .rr_ptr    (rr_ptr),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign ucq2eng_ready = grant;
    assign dec_ready     = !rst_n && (state == IDLE) && (count == '0) && !(|eng2ucq_valid);

    assign push_eng = |grant;
    assign push_dec = dec_valid && dec_ready;
    assign push     = push_eng || push_dec;
    assign push_lit = push_dec ? dec_lit : eng2ucq_lit[grant_idx];
    assign pop      = (state == ISSUE);
    assign flush    = (state == CONFLICT);

    always_comb begin
        state_next     = state;
        done_mask_next = done_mask;
        count_next     = count;
        if (push) count_next = count_next + CW'(1);
        if (pop)  count_next = count_next - CW'(1);
        if (flush) count_next = '0;

        case (state)
            IDLE: begin
                if (count != '0) state_next = ISSUE;
            end
            ISSUE: begin
                done_mask_next = '0;
                state_next     = (|eng2ucq_conflict) ? CONFLICT : WAIT;
            end
            WAIT: begin
                done_mask_next = done_mask | eng2ucq_done;
                // Conflict wins over a completion landing in the same cycle.
                if (|eng2ucq_conflict)
                    state_next = CONFLICT;
                else if (&(done_mask | eng2ucq_done))
                    state_next = (count_next != '0) ? ISSUE : IDLE;
            end
            CONFLICT: begin
                done_mask_next = '0;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            rr_ptr    <= '0;
            done_mask <= '0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            done_mask <= done_mask_next;
            if (flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push) tail <= tail + PW'(1);
                if (pop)  head <= head + PW'(1);
            end
            if (push_eng)
                rr_ptr <= (grant_idx == EW'(NUM_ENG - 1)) ? '0 : grant_idx + EW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_lit;
    end

    assign ucarb2clq_uc_rqst       = (state == ISSUE) ? mem[head] : '0;
    assign ucarb2clq_uc_rqst_valid = (state == ISSUE);
    assign sched_conflict          = (state == CONFLICT);
    assign sched_busy              = (state != IDLE) || (count != '0);
    assign ucq_count               = count;

endmodule

// File: tb/tb_ucq_scheduler.sv
// Scoreboard bench for ucq_scheduler: directed stimulus pushes expected broadcasts, a monitor pops them.
module tb_ucq_scheduler;
    import sat_pkg::*;

    localparam int NE = NUM_ENG;

    typedef struct {
        int lit;
        int cyc;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rst_n;
    lit_t                        dec_lit;
    logic                        dec_valid;
    logic                        dec_ready;
    lit_t                        eng_lit [NE];
    logic [NE-1:0]               eng_valid;
    logic [NE-1:0]               eng_ready;
    logic [NE-1:0]               eng_done;
    logic [NE-1:0]               eng_conflict;
    lit_t                        rqst;
    logic                        rqst_valid;
    logic                        sched_busy;
    logic                        sched_conflict;
    logic [$clog2(UCQ_DEPTH):0]  ucq_count;

    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    exp_t          exp_q [$];
    int            eng_q [NE][$];
    int            dly   [NE];
    int            due   [NE];
    logic [NE-1:0] grant_seen = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ucq_scheduler dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .dec_lit                 (dec_lit),
        .dec_valid               (dec_valid),
        .dec_ready               (dec_ready),
        .eng2ucq_lit             (eng_lit),
        .eng2ucq_valid           (eng_valid),
        .ucq2eng_ready           (eng_ready),
        .eng2ucq_done            (eng_done),
        .eng2ucq_conflict        (eng_conflict),
        .ucarb2clq_uc_rqst       (rqst),
        .ucarb2clq_uc_rqst_valid (rqst_valid),
        .sched_busy              (sched_busy),
        .sched_conflict          (sched_conflict),
        .ucq_count               (ucq_count)
    );

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic expect_rq(input int lit, input int c);
        exp_t x;
        x.lit = lit;
        x.cyc = c;
        exp_q.push_back(x);
    endtask

    function automatic bit all_q_empty();
        bit e_ok = 1'b1;
        for (int e = 0; e < NE; e++)
            if (eng_q[e].size() != 0) e_ok = 1'b0;
        return e_ok;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sched_busy || eng_valid != '0 || !all_q_empty()) && n < 400);
        chk({name, "_idle_within_budget"}, int'(n < 400), 1);
    endtask

    // Monitor: latch grants for the engine model, schedule done pulses, score broadcasts.
    initial begin
        exp_t x;
        for (int e = 0; e < NE; e++) due[e] = -1;
        forever begin
            @(negedge clk);
            grant_seen = eng_ready & eng_valid;
            if (rqst_valid) begin
                for (int e = 0; e < NE; e++) due[e] = cyc + dly[e];
                if (exp_q.size() == 0) begin
                    chk("rqst_unexpected", int'(rqst), -999);
                end else begin
                    x = exp_q.pop_front();
                    chk("rqst_lit", int'(rqst), x.lit);
                    if (x.cyc >= 0) chk("rqst_cycle", cyc, x.cyc);
                end
            end
        end
    end

    // Engine model: holds valid until granted, pulses done dly[e] cycles after each broadcast.
    initial begin
        eng_valid = '0;
        eng_done  = '0;
        for (int e = 0; e < NE; e++) eng_lit[e] = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int e = 0; e < NE; e++) begin
                if (grant_seen[e] && eng_q[e].size() > 0) void'(eng_q[e].pop_front());
                eng_valid[e] = (eng_q[e].size() > 0);
                eng_lit[e]   = (eng_q[e].size() > 0) ? lit_t'(eng_q[e][0]) : '0;
                eng_done[e]  = (cyc == due[e]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        int full_order [17] = '{11, 21, 31, 1, 12, 22, 32, 2, 13, 23, 33, 3, 14, 24, 34, 4, 15};

        rst_n        = 1'b1;
        dec_lit      = '0;
        dec_valid    = 1'b0;
        eng_conflict = '0;
        for (int e = 0; e < NE; e++) dly[e] = 1;

        repeat (3) @(negedge clk);
        chk("rst_rqst_valid", int'(rqst_valid), 0);
        chk("rst_busy", int'(sched_busy), 0);
        chk("rst_count", int'(ucq_count), 0);
        chk("rst_conflict", int'(sched_conflict), 0);
        chk("rst_dec_ready", int'(dec_ready), 0);
        rst_n = 1'b0;

        // Decision literal latency
        @(negedge clk);
        t0        = cyc;
        dec_lit   = 5;
        dec_valid = 1'b1;
        #1;
        chk("dec_ready_c0", int'(dec_ready), 1);
        expect_rq(5, t0 + 2);
        @(negedge clk);
        dec_valid = 1'b0;
        chk("c1_busy", int'(sched_busy), 1);
        chk("c1_count", int'(ucq_count), 1);
        chk("c1_rqst_valid", int'(rqst_valid), 0);
        wait_idle("dec");

        // Round-robin from rr_ptr=0 with engines 0 and 2
        t0 = cyc + 1;
        eng_q[0].push_back(3);
        eng_q[2].push_back(-7);
        expect_rq(3, t0 + 2);
        expect_rq(-7, t0 + 4);
        @(negedge clk);
        chk("rr_grant_k", int'(eng_ready), 1);
        @(negedge clk);
        chk("rr_grant_k1", int'(eng_ready), 4);
        wait_idle("rr");

        // rr_ptr now 3: engine 3 first, then wrap to engine 0
        eng_q[0].push_back(12);
        eng_q[3].push_back(11);
        expect_rq(11, -1);
        expect_rq(12, -1);
        @(negedge clk);
        chk("rr_wrap_k", int'(eng_ready), 8);
        @(negedge clk);
        chk("rr_wrap_k1", int'(eng_ready), 1);
        wait_idle("rr_wrap");

        // Fill the FIFO during a long WAIT
        for (int e = 0; e < NE; e++) dly[e] = 40;
        t0        = cyc;
        dec_lit   = 50;
        dec_valid = 1'b1;
        expect_rq(50, t0 + 2);
        @(negedge clk);
        dec_valid = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 4; j++)
            for (int e = 0; e < NE; e++) eng_q[e].push_back(10 * e + j + 1);
        eng_q[1].push_back(15);
        for (int i = 0; i < 17; i++) expect_rq(full_order[i], -1);
        repeat (20) @(negedge clk);
        chk("full_count", int'(ucq_count), 16);
        chk("full_ready", int'(eng_ready), 0);
        chk("full_busy", int'(sched_busy), 1);
        for (int e = 0; e < NE; e++) dly[e] = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rqst_valid && n < 100);
        chk("full_issue_seen", int'(rqst_valid), 1);
        chk("full_ready_at_issue", int'(eng_ready), 0);
        @(negedge clk);
        chk("full_ready_after_pop", int'(eng_ready), 2);
        wait_idle("full");

        // Staggered completion: done at +1,+2,+6,+4 after ISSUE
        dly[0] = 1;
        dly[1] = 2;
        dly[2] = 6;
        dly[3] = 4;
        t0        = cyc;
        dec_lit   = 7;
        dec_valid = 1'b1;
        expect_rq(7, t0 + 2);
        expect_rq(8, t0 + 9);
        @(negedge clk);
        dec_valid = 1'b0;
        eng_q[2].push_back(8);
        wait_idle("stagger");

        // Conflict with four entries queued
        for (int e = 0; e < NE; e++) dly[e] = 40;
        t0        = cyc;
        dec_lit   = 40;
        dec_valid = 1'b1;
        expect_rq(40, t0 + 2);
        @(negedge clk);
        dec_valid = 1'b0;
        @(negedge clk);
        for (int e = 0; e < NE; e++) eng_q[e].push_back(41 + e);
        repeat (6) @(negedge clk);
        chk("cfl_count_before", int'(ucq_count), 4);
        eng_conflict = 4'b0010;
        @(negedge clk);
        eng_conflict = '0;
        chk("cfl_strobe", int'(sched_conflict), 1);
        @(negedge clk);
        chk("cfl_strobe_single", int'(sched_conflict), 0);
        chk("cfl_count_flushed", int'(ucq_count), 0);
        chk("cfl_idle", int'(sched_busy), 0);
        repeat (40) @(negedge clk);
        chk("cfl_still_idle", int'(sched_busy), 0);

        // Asynchronous reset mid-WAIT
        t0        = cyc;
        dec_lit   = 60;
        dec_valid = 1'b1;
        expect_rq(60, t0 + 2);
        @(negedge clk);
        dec_valid = 1'b0;
        @(negedge clk);
        eng_q[3].push_back(61);
        eng_q[0].push_back(62);
        repeat (4) @(negedge clk);
        eng_q[1].push_back(63);
        @(posedge clk);
        #2;
        chk("pre_rst_ready", int'(eng_ready), 2);
        chk("pre_rst_count", int'(ucq_count), 2);
        rst_n = 1'b1;
        #1;
        chk("arst_rqst_valid", int'(rqst_valid), 0);
        chk("arst_ready", int'(eng_ready), 0);
        chk("arst_busy", int'(sched_busy), 0);
        chk("arst_count", int'(ucq_count), 0);
        for (int e = 0; e < NE; e++) dly[e] = 1;
        expect_rq(63, -1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        wait_idle("post_rst");

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
